mcp_frame_encoder: RTL and testbench

Transmit-side counterpart of the memory-controller-protocol (MCP) response decoder. Accepts one command (instruction, address, data) and builds a 12-byte MCP frame: Start 1B | Header 2B | Payload 7B | Error 1B | End 1B. It serialises the frame byte-by-byte over a valid/ready link toward the UART transmitter, then waits for the decoded response flags (wait/ready/retry). Retransmits on request or timeout, up to a retry limit.

---
 rtl/mcp_frame_encoder_pkg.sv | 59 +++++
 rtl/mcp_frame_encoder_if.sv | 29 ++
 rtl/mcp_frame_encoder_tx_byte_mux.sv | 18 +
 rtl/mcp_frame_encoder.sv | 128 ++++++++++++
 tb/tb_mcp_frame_encoder.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mcp_frame_encoder_pkg.sv
// mcp_pkg: shared types and helpers for the MCP frame encoder.
//   - FSM state enum, frame geometry and field bit positions
//   - MCP response codes as decoded upstream (wait/ready/retry)
//   - check-byte functions: plain XOR, or CRC-8 when
//     MCP_FRAME_ENCODER_CRC8_EN is defined
package mcp_pkg;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      SEND       = 2'd1,
      AWAIT_RESP = 2'd2
   } mcpState_t;

   typedef enum logic [15:0] {
      RESP_WAIT  = 16'hFFF1,
      RESP_READY = 16'hFFF2,
      RESP_RETRY = 16'hFFF3
   } mcpResp_t;

   localparam int FRAME_BYTES = 12;
   localparam int FRAME_BITS  = 8 * FRAME_BYTES;

   // Field LSB positions inside the 96-bit frame image (byte0 at the MSB).
   localparam int START_LSB = 88;
   localparam int INSTR_LSB = 72;
   localparam int ADDR_LSB  = 48;
   localparam int DATA_LSB  = 16;
   localparam int CHECK_LSB = 8;
   localparam int END_LSB   = 0;

   // body = frame bytes 1..9, byte1 in the top 8 bits.
   function automatic logic [7:0] checkXor(input logic [71:0] body);
      logic [7:0] acc;
      acc = 8'h00;
      for (int i = 0; i < 9; i++) acc = acc ^ body[8*i +: 8];
      return acc;
   endfunction

   // CRC-8, poly 0x07, init 0, MSB-first, no reflection, no final XOR.
   function automatic logic [7:0] checkCrc8(input logic [71:0] body);
      logic [7:0] crc;
      logic       fb;
      crc = 8'h00;
      for (int i = 71; i >= 0; i--) begin
         fb  = crc[7] ^ body[i];
         crc = {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
      end
      return crc;
   endfunction

   function automatic logic [7:0] checkByte(input logic [71:0] body);
`ifdef MCP_FRAME_ENCODER_CRC8_EN
      return checkCrc8(body);
`else
      return checkXor(body);
`endif
   endfunction

endpackage

// File: rtl/mcp_frame_encoder_if.sv
// Command, byte-stream and response-flag bundle of the MCP frame encoder.
//   master : the encoder (drives oBusy/oTxByte/oTxValid/oDone/oError/oFrame)
//   slave  : command source, UART TX and response decoder side
interface mcp_frame_encoder_if;
   logic        iStart;
   logic [15:0] iInstruction;
   logic [23:0] iAddr;
   logic [31:0] iData;
   logic        oBusy;
   logic [7:0]  oTxByte;
   logic        oTxValid;
   logic        iTxReady;
   logic        iWait;
   logic        iReady;
   logic        iRetry;
   logic        oDone;
   logic        oError;
   logic [95:0] oFrame;

   modport master (
      input  iStart, iInstruction, iAddr, iData, iTxReady, iWait, iReady, iRetry,
      output oBusy, oTxByte, oTxValid, oDone, oError, oFrame
   );

   modport slave (
      output iStart, iInstruction, iAddr, iData, iTxReady, iWait, iReady, iRetry,
      input  oBusy, oTxByte, oTxValid, oDone, oError, oFrame
   );
endinterface

// File: rtl/mcp_frame_encoder_tx_byte_mux.sv
// mcp_tx_byte_mux: picks frame byte [index] (0..11, byte0 = MSB byte).
//   frame  in  96  registered frame image
//   index  in  4   byte index
//   txByte out 8   selected byte (0 for out-of-range index)
import mcp_pkg::*;

module mcp_tx_byte_mux (
   input  logic [FRAME_BITS-1:0] frame,
   input  logic [3:0]            index,
   output logic [7:0]            txByte
);
   always_comb begin
      txByte = 8'h00;
      for (int i = 0; i < FRAME_BYTES; i++) begin
         if (index == 4'(i)) txByte = frame[FRAME_BITS-1-8*i -: 8];
      end
   end
endmodule

// File: rtl/mcp_frame_encoder.sv
// mcp_frame_encoder: captures one command, serialises a 12-byte MCP frame
// over a valid/ready link and waits for the decoded response, resending on
// retry request or response timeout up to MAX_RETRY times.
//   clk, reset (sync, active-low)
//   bus (master): iStart/iInstruction/iAddr/iData command, oTxByte/oTxValid/
//                 iTxReady stream, iWait/iReady/iRetry flags, oBusy/oDone/
//                 oError status, oFrame captured frame image
// Build option: MCP_FRAME_ENCODER_CRC8_EN selects CRC-8 check byte, else XOR.
//
// state      | meaning
// IDLE       | waiting for iStart
// SEND       | presenting frame byte [byteIdx] on the stream
// AWAIT_RESP | frame sent, waiting for ready/retry/wait or timeout
import mcp_pkg::*;

module mcp_frame_encoder #(
   parameter logic [7:0] START_BYTE   = 8'h0F,
   parameter logic [7:0] END_BYTE     = 8'hF0,
   parameter int         MAX_RETRY    = 3,
   parameter int         RESP_TIMEOUT = 1024
) (
   input  logic                clk,
   input  logic                reset,
   mcp_frame_encoder_if.master bus
);
   localparam int RETRY_W = ($clog2(MAX_RETRY + 1) < 2) ? 2 : $clog2(MAX_RETRY + 1);
   localparam int TMO_W   = $clog2(RESP_TIMEOUT);

   mcpState_t             state;
   logic [FRAME_BITS-1:0] frameQ;
   logic [FRAME_BITS-1:0] newFrame;
   logic [3:0]            byteIdx;
   logic [RETRY_W-1:0]    retryCnt;
   logic [TMO_W-1:0]      timeoutCnt;
   logic                  txValid;
   logic                  busy;
   logic                  done;
   logic                  error;
   logic [7:0]            txByte;

   always_comb begin
      newFrame = '0;
      newFrame[START_LSB +: 8]  = START_BYTE;
      newFrame[INSTR_LSB +: 16] = bus.iInstruction;
      newFrame[ADDR_LSB  +: 24] = bus.iAddr;
      newFrame[DATA_LSB  +: 32] = bus.iData;
      newFrame[CHECK_LSB +: 8]  = checkByte({bus.iInstruction, bus.iAddr, bus.iData});
      newFrame[END_LSB   +: 8]  = END_BYTE;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= IDLE;
         frameQ     <= '0;
         byteIdx    <= '0;
         retryCnt   <= '0;
         timeoutCnt <= '0;
         txValid    <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         error      <= 1'b0;
      end else begin
         done  <= 1'b0;
         error <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.iStart) begin
                  frameQ   <= newFrame;
                  byteIdx  <= '0;
                  retryCnt <= '0;
                  txValid  <= 1'b1;
                  busy     <= 1'b1;
                  state    <= SEND;
               end
            end
            SEND: begin
               if (bus.iTxReady) begin
                  if (byteIdx == 4'(FRAME_BYTES - 1)) begin
                     // Valid drops with the last accept: no bubble byte.
                     byteIdx    <= '0;
                     timeoutCnt <= '0;
                     txValid    <= 1'b0;
                     state      <= AWAIT_RESP;
                  end else begin
                     byteIdx <= byteIdx + 4'd1;
                  end
               end
            end
            AWAIT_RESP: begin
               if (bus.iReady) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= IDLE;
               end else if (bus.iRetry || timeoutCnt == TMO_W'(RESP_TIMEOUT - 1)) begin
                  if (retryCnt < RETRY_W'(MAX_RETRY)) begin
                     retryCnt <= retryCnt + 1'b1;
                     byteIdx  <= '0;
                     txValid  <= 1'b1;
                     state    <= SEND;
                  end else begin
                     busy  <= 1'b0;
                     error <= 1'b1;
                     state <= IDLE;
                  end
               end else if (bus.iWait) begin
                  timeoutCnt <= '0;
               end else begin
                  timeoutCnt <= timeoutCnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   mcp_tx_byte_mux uByteMux (
      .frame  (frameQ),
      .index  (byteIdx),
      .txByte (txByte)
   );

   assign bus.oTxByte  = txByte;
   assign bus.oTxValid = txValid;
   assign bus.oBusy    = busy;
   assign bus.oDone    = done;
   assign bus.oError   = error;
   assign bus.oFrame   = frameQ;
endmodule

// File: tb/tb_mcp_frame_encoder.sv
module tb_mcp_frame_encoder;
   localparam int MAX_RETRY    = 3;
   localparam int RESP_TIMEOUT = 1024;

   logic clk = 1'b0;
   logic reset;
   int   vectors = 0;
   int   miscompares = 0;

   mcp_frame_encoder_if bus ();

   mcp_frame_encoder #(
      .START_BYTE   (8'h0F),
      .END_BYTE     (8'hF0),
      .MAX_RETRY    (MAX_RETRY),
      .RESP_TIMEOUT (RESP_TIMEOUT)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Reference frame built from the field layout rules.
   function automatic logic [95:0] model_frame(input logic [15:0] ins, input logic [23:0] a,
                                               input logic [31:0] d);
      logic [7:0]  b [12];
      logic [71:0] body;
      logic [7:0]  chk;
      logic [95:0] f;
      body = {ins, a, d};
      b[0] = 8'h0F;
      for (int k = 1; k <= 9; k++) b[k] = body[71 - 8*(k-1) -: 8];
      chk = 8'h00;
`ifdef MCP_FRAME_ENCODER_CRC8_EN
      for (int k = 1; k <= 9; k++) begin
         chk = chk ^ b[k];
         for (int j = 0; j < 8; j++) chk = chk[7] ? ({chk[6:0], 1'b0} ^ 8'h07) : {chk[6:0], 1'b0};
      end
`else
      for (int k = 1; k <= 9; k++) chk = chk ^ b[k];
`endif
      b[10] = chk;
      b[11] = 8'hF0;
      f = '0;
      for (int k = 0; k < 12; k++) f[95 - 8*k -: 8] = b[k];
      return f;
   endfunction

   task automatic issue(input logic [15:0] ins, input logic [23:0] a, input logic [31:0] d);
      bus.iInstruction = ins;
      bus.iAddr        = a;
      bus.iData        = d;
      bus.iStart       = 1'b1;
      tick;
      bus.iStart       = 1'b0;
      bus.iInstruction = 16'($urandom);
      bus.iAddr        = 24'($urandom);
      bus.iData        = $urandom;
   endtask

   // Collects accepted bytes; counts stall-stability violations. No checking here.
   task automatic grab_frame(input bit randReady, input bit noise, output logic [95:0] got,
                             output int nGot, output int unstable);
      logic [7:0] prevByte;
      bit         havePrev;
      bit         rdy;
      int         cycles;
      got = '0; nGot = 0; unstable = 0; cycles = 0; havePrev = 0; prevByte = 8'h00;
      while (nGot < 12 && cycles < 400) begin
         if (havePrev && (bus.oTxValid !== 1'b1 || bus.oTxByte !== prevByte)) unstable++;
         rdy = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
         bus.iTxReady = rdy;
         if (noise) begin
            bus.iRetry = 1'($urandom_range(0, 1));
            bus.iStart = 1'($urandom_range(0, 1));
            bus.iData  = $urandom;
         end
         havePrev = 0;
         if (bus.oTxValid === 1'b1) begin
            if (rdy) begin
               got[95 - 8*nGot -: 8] = bus.oTxByte;
               nGot++;
            end else begin
               havePrev = 1;
               prevByte = bus.oTxByte;
            end
         end
         tick;
         cycles++;
      end
      bus.iTxReady = 1'b1;
      bus.iRetry   = 1'b0;
      bus.iStart   = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b0;
      repeat (2) tick;
      vectors++;
      if ({bus.oBusy, bus.oTxValid, bus.oDone, bus.oError, bus.oTxByte} !== 12'h000 ||
          bus.oFrame !== 96'h0) begin
         miscompares++;
         $display("FAIL reset_outputs: busy=%b valid=%b done=%b err=%b byte=%h frame=%h, want all 0",
                  bus.oBusy, bus.oTxValid, bus.oDone, bus.oError, bus.oTxByte, bus.oFrame);
      end
      reset = 1'b1;
      tick;
      vectors++;
      if (bus.oBusy !== 1'b0 || bus.oTxValid !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_idle: busy=%b valid=%b, want 0 0", bus.oBusy, bus.oTxValid);
      end
   endtask

   task automatic test_basic;
      logic [95:0] got, exp;
      int n, uns;
      logic [15:0] ins; logic [23:0] a; logic [31:0] d;
      for (int t = 0; t < 5; t++) begin
         if (t == 0) begin ins = 16'h0001; a = 24'h000100; d = 32'hDEADBEEF; end
         else begin ins = 16'($urandom); a = 24'($urandom); d = $urandom; end
         exp = model_frame(ins, a, d);
         bus.iTxReady = 1'b1;
         issue(ins, a, d);
         vectors++;
         if (bus.oTxValid !== 1'b1 || bus.oTxByte !== 8'h0F) begin
            miscompares++;
            $display("FAIL basic_first_byte: valid=%b byte=%h, want 1 0f", bus.oTxValid, bus.oTxByte);
         end
         grab_frame(1'b0, 1'b0, got, n, uns);
         vectors++;
         if (n != 12 || got !== exp || bus.oFrame !== exp) begin
            miscompares++;
            $display("FAIL basic_frame: n=%0d got=%h frame=%h, want %h", n, got, bus.oFrame, exp);
         end
`ifndef MCP_FRAME_ENCODER_CRC8_EN
         if (t == 0) begin
            vectors++;
            if (got !== 96'h0F_0001_000100_DEADBEEF_22_F0) begin
               miscompares++;
               $display("FAIL basic_literal: got=%h, want 0f0001000100deadbeef22f0", got);
            end
         end
`endif
         vectors++;
         if (bus.oTxValid !== 1'b0 || bus.oBusy !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_await: valid=%b busy=%b, want 0 1", bus.oTxValid, bus.oBusy);
         end
         repeat ($urandom_range(0, 3)) tick;
         bus.iReady = 1'b1;
         tick;
         bus.iReady = 1'b0;
         vectors++;
         if (bus.oDone !== 1'b1 || bus.oBusy !== 1'b0 || bus.oError !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_done: done=%b busy=%b err=%b, want 1 0 0", bus.oDone, bus.oBusy, bus.oError);
         end
         tick;
         vectors++;
         if (bus.oDone !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_done_pulse: done=%b, want 0", bus.oDone);
         end
      end
   endtask

   task automatic test_backpressure;
      logic [95:0] got, exp;
      int n, uns;
      logic [15:0] ins; logic [23:0] a; logic [31:0] d;
      for (int t = 0; t < 4; t++) begin
         ins = 16'($urandom); a = 24'($urandom); d = $urandom;
         exp = model_frame(ins, a, d);
         issue(ins, a, d);
         grab_frame(1'b1, 1'b0, got, n, uns);
         vectors++;
         if (n != 12 || got !== exp || uns != 0) begin
            miscompares++;
            $display("FAIL bp_frame: n=%0d unstable=%0d got=%h, want 12 0 %h", n, uns, got, exp);
         end
         vectors++;
         if (bus.oTxValid !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_no_bubble: valid=%b, want 0", bus.oTxValid);
         end
         bus.iReady = 1'b1;
         tick;
         bus.iReady = 1'b0;
         vectors++;
         if (bus.oDone !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_done: done=%b, want 1", bus.oDone);
         end
      end
   endtask

   task automatic test_retry;
      logic [95:0] got, exp;
      int n, uns;
      logic [15:0] ins; logic [23:0] a; logic [31:0] d;
      for (int phase = 0; phase < 2; phase++) begin
         ins = 16'($urandom); a = 24'($urandom); d = $urandom;
         exp = model_frame(ins, a, d);
         issue(ins, a, d);
         for (int r = 0; r <= MAX_RETRY; r++) begin
            grab_frame(1'b0, 1'b0, got, n, uns);
            vectors++;
            if (n != 12 || got !== exp) begin
               miscompares++;
               $display("FAIL retry_frame[%0d.%0d]: n=%0d got=%h, want %h", phase, r, n, got, exp);
            end
            if (phase == 0 && r == MAX_RETRY) break;
            repeat ($urandom_range(0, 4)) tick;
            bus.iRetry = 1'b1;
            tick;
            bus.iRetry = 1'b0;
            if (r == MAX_RETRY) begin
               vectors++;
               if (bus.oError !== 1'b1 || bus.oDone !== 1'b0 || bus.oBusy !== 1'b0 || bus.oTxValid !== 1'b0) begin
                  miscompares++;
                  $display("FAIL retry_exhausted: err=%b done=%b busy=%b valid=%b, want 1 0 0 0",
                           bus.oError, bus.oDone, bus.oBusy, bus.oTxValid);
               end
               tick;
               vectors++;
               if (bus.oError !== 1'b0 || bus.oTxValid !== 1'b0) begin
                  miscompares++;
                  $display("FAIL retry_err_pulse: err=%b valid=%b, want 0 0", bus.oError, bus.oTxValid);
               end
            end else begin
               vectors++;
               if (bus.oTxValid !== 1'b1 || bus.oError !== 1'b0) begin
                  miscompares++;
                  $display("FAIL retry_resend[%0d]: valid=%b err=%b, want 1 0", r, bus.oTxValid, bus.oError);
               end
            end
         end
         if (phase == 0) begin
            bus.iReady = 1'b1;
            tick;
            bus.iReady = 1'b0;
            vectors++;
            if (bus.oDone !== 1'b1 || bus.oError !== 1'b0 || bus.oBusy !== 1'b0) begin
               miscompares++;
               $display("FAIL retry_done: done=%b err=%b busy=%b, want 1 0 0", bus.oDone, bus.oError, bus.oBusy);
            end
         end
      end
   endtask

   task automatic test_timeout_wait;
      logic [95:0] got, exp;
      int n, uns, waited;
      bit sawResend;
      logic [15:0] ins; logic [23:0] a; logic [31:0] d;
      ins = 16'($urandom); a = 24'($urandom); d = $urandom;
      exp = model_frame(ins, a, d);
      issue(ins, a, d);
      grab_frame(1'b0, 1'b0, got, n, uns);
      waited = 0;
      while (bus.oTxValid !== 1'b1 && waited < RESP_TIMEOUT + 50) begin
         tick;
         waited++;
      end
      vectors++;
      if (waited != RESP_TIMEOUT) begin
         miscompares++;
         $display("FAIL timeout_resend: resend after %0d cycles, want %0d", waited, RESP_TIMEOUT);
      end
      grab_frame(1'b0, 1'b0, got, n, uns);
      vectors++;
      if (n != 12 || got !== exp) begin
         miscompares++;
         $display("FAIL timeout_frame: n=%0d got=%h, want %h", n, got, exp);
      end
      sawResend = 0;
      for (int c = 1; c <= 1600; c++) begin
         bus.iWait = (c % 500 == 0);
         tick;
         if (bus.oTxValid !== 1'b0 || bus.oBusy !== 1'b1) sawResend = 1;
      end
      bus.iWait = 1'b0;
      vectors++;
      if (sawResend) begin
         miscompares++;
         $display("FAIL wait_holds: resend or idle seen=%b, want 0", sawResend);
      end
      bus.iReady = 1'b1;
      tick;
      bus.iReady = 1'b0;
      vectors++;
      if (bus.oDone !== 1'b1) begin
         miscompares++;
         $display("FAIL wait_done: done=%b, want 1", bus.oDone);
      end
   endtask

   task automatic test_coincident;
      logic [95:0] got, exp;
      int n, uns;
      logic [15:0] ins; logic [23:0] a; logic [31:0] d;
      ins = 16'($urandom); a = 24'($urandom); d = $urandom;
      exp = model_frame(ins, a, d);
      issue(ins, a, d);
      grab_frame(1'b1, 1'b1, got, n, uns);
      vectors++;
      if (n != 12 || got !== exp || bus.oFrame !== exp || uns != 0) begin
         miscompares++;
         $display("FAIL noise_frame: n=%0d unstable=%0d got=%h frame=%h, want %h", n, uns, got, bus.oFrame, exp);
      end
      bus.iReady = 1'b1;
      bus.iRetry = 1'b1;
      tick;
      bus.iReady = 1'b0;
      bus.iRetry = 1'b0;
      vectors++;
      if (bus.oDone !== 1'b1 || bus.oError !== 1'b0 || bus.oTxValid !== 1'b0 || bus.oBusy !== 1'b0) begin
         miscompares++;
         $display("FAIL coincident_done: done=%b err=%b valid=%b busy=%b, want 1 0 0 0",
                  bus.oDone, bus.oError, bus.oTxValid, bus.oBusy);
      end
      tick;
      vectors++;
      if (bus.oTxValid !== 1'b0 || bus.oDone !== 1'b0) begin
         miscompares++;
         $display("FAIL coincident_no_resend: valid=%b done=%b, want 0 0", bus.oTxValid, bus.oDone);
      end
   endtask

   task automatic test_reset_mid;
      logic [95:0] got, exp;
      int n, uns;
      bit reissued;
      logic [15:0] ins; logic [23:0] a; logic [31:0] d;
      ins = 16'($urandom); a = 24'($urandom); d = $urandom;
      exp = model_frame(ins, a, d);
      bus.iTxReady = 1'b1;
      issue(ins, a, d);
      repeat (5) tick;
      vectors++;
      if (bus.oTxValid !== 1'b1 || bus.oTxByte !== exp[95 - 40 -: 8]) begin
         miscompares++;
         $display("FAIL midreset_byte5: valid=%b byte=%h, want 1 %h", bus.oTxValid, bus.oTxByte, exp[95 - 40 -: 8]);
      end
      reset = 1'b0;
      tick;
      vectors++;
      if ({bus.oBusy, bus.oTxValid, bus.oDone, bus.oError, bus.oTxByte} !== 12'h000 ||
          bus.oFrame !== 96'h0) begin
         miscompares++;
         $display("FAIL midreset_clear: busy=%b valid=%b done=%b err=%b byte=%h frame=%h, want all 0",
                  bus.oBusy, bus.oTxValid, bus.oDone, bus.oError, bus.oTxByte, bus.oFrame);
      end
      reset = 1'b1;
      reissued = 0;
      repeat (4) begin
         tick;
         if (bus.oTxValid !== 1'b0 || bus.oBusy !== 1'b0) reissued = 1;
      end
      vectors++;
      if (reissued) begin
         miscompares++;
         $display("FAIL midreset_idle: activity after reset=%b, want 0", reissued);
      end
      ins = 16'($urandom); a = 24'($urandom); d = $urandom;
      exp = model_frame(ins, a, d);
      issue(ins, a, d);
      grab_frame(1'b0, 1'b0, got, n, uns);
      vectors++;
      if (n != 12 || got !== exp) begin
         miscompares++;
         $display("FAIL midreset_fresh: n=%0d got=%h, want %h", n, got, exp);
      end
      bus.iReady = 1'b1;
      tick;
      bus.iReady = 1'b0;
      vectors++;
      if (bus.oDone !== 1'b1) begin
         miscompares++;
         $display("FAIL midreset_done: done=%b, want 1", bus.oDone);
      end
   endtask

   initial begin
      reset            = 1'b0;
      bus.iStart       = 1'b0;
      bus.iInstruction = '0;
      bus.iAddr        = '0;
      bus.iData        = '0;
      bus.iTxReady     = 1'b1;
      bus.iWait        = 1'b0;
      bus.iReady       = 1'b0;
      bus.iRetry       = 1'b0;
      test_reset;
      test_basic;
      test_backpressure;
      test_retry;
      test_timeout_wait;
      test_coincident;
      test_reset_mid;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
